// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer for the 16-bit ALU: accepts an instruction, reads two
// registers, presents operands to the combinational ALU and issues a one-cycle writeback.
module alu_issue_ctrl #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [AW-1:0] rs_addr,
    output logic [AW-1:0] rm_addr,
    input  logic [DW-1:0] rs_rdata,
    input  logic [DW-1:0] rm_rdata,
    output logic [DW-1:0] alu_rsdata,
    output logic [DW-1:0] alu_rmdata,
    output logic [DW-1:0] alu_n,
    output logic          alu_bit15,
    output logic [1:0]    alu_bits12_11,
    output logic          alu_bit4,
    input  logic [DW-1:0] alu_result,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          illegal,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   instr_q;
    logic [DW-1:0] rs_q;
    logic [DW-1:0] rm_q;
    logic [DW-1:0] wb_q;
    logic          accept;
    logic          legal;

    assign accept = instr_valid && instr_ready;

    // A word is legal when bits 14:13 are clear and {bit15, bits12:11} is not 3'b111
    assign legal = (instr_q[14:13] == 2'b00) &&
                   !(instr_q[15] && (instr_q[12:11] == 2'b11));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            instr_q <= '0;
            rs_q    <= '0;
            rm_q    <= '0;
            wb_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                instr_q <= instr;
            end
            if ((state == READ) && legal) begin
                rs_q <= rs_rdata;
                rm_q <= rm_rdata;
            end
            if (state == EXEC) begin
                wb_q <= alu_result;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        illegal     = 1'b0;
        wb_en       = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (!legal) begin
                    illegal   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = WB;
            end
            WB: begin
                wb_en     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The register file reads synchronously, so the addresses are presented on the
    // accept edge itself; the data then arrives during READ and is registered into EXEC.
    assign rs_addr = (state == IDLE && instr_valid) ? instr[10:8] : instr_q[10:8];
    assign rm_addr = (state == IDLE && instr_valid) ? instr[7:5]  : instr_q[7:5];

    assign alu_rsdata    = rs_q;
    assign alu_rmdata    = rm_q;
    assign alu_n         = {{(DW-8){1'b0}}, instr_q[7:0]};
    assign alu_bit15     = instr_q[15];
    assign alu_bits12_11 = instr_q[12:11];
    assign alu_bit4      = instr_q[4];

    assign wb_addr = instr_q[10:8];
    assign wb_data = wb_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle control sequencer that drives the 16-bit ALU datapath and consumes its result.
- Accepts one instruction word per handshake and decodes the ALU fields: bit 15, bits 12:11, bit 4, the register indices and the immediate.
- Reads two operands from the synchronous register file, presents operands and decoded bits to the combinational ALU, captures the ALU result and issues a one-cycle register writeback.
- Sits between the fetch stage and the register file/ALU pair.

Parameters:
- DW, 16, datapath width.
- AW, 3, register address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction word available.
- instr  in  16  instruction word.
- instr_ready  out  1  block can accept an instruction.
- rs_addr  out  AW  register file read address A, equal to instr[10:8].
- rm_addr  out  AW  register file read address B, equal to instr[7:5].
- rs_rdata  in  DW  read data A, valid one cycle after address.
- rm_rdata  in  DW  read data B, valid one cycle after address.
- alu_rsdata  out  DW  ALU operand rs.
- alu_rmdata  out  DW  ALU operand rm.
- alu_n  out  DW  immediate, zero-extended instr[7:0].
- alu_bit15  out  1  decoded instr[15].
- alu_bits12_11  out  2  decoded instr[12:11].
- alu_bit4  out  1  decoded instr[4].
- alu_result  in  DW  combinational ALU output.
- wb_en  out  1  register write strobe.
- wb_addr  out  AW  write address, equal to rs index.
- wb_data  out  DW  write data.
- illegal  out  1  one-cycle pulse: instruction rejected.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State goes to IDLE; the instruction register clears to 0.
  - All outputs are 0 except instr_ready, which is 1.
- Handshake:
  - An instruction is accepted when instr_valid && instr_ready on a rising edge.
  - instr_ready = 1 only in IDLE; instr is latched on accept.
  - instr_valid may stay high; no transfer occurs while instr_ready = 0.
- Decode (on the latched word):
  - ALU-class requires instr[14:13] == 2'b00.
  - Opcode {instr[15], instr[12:11], instr[4]} in {111x} is unsupported.
  - Anything else outside the ALU class is also unsupported.
- FSM (accept edge = cycle 0):
  - IDLE: on accept, go to READ.
  - READ (cycle 1):
    - Drive rs_addr/rm_addr from the latched word.
    - Unsupported word: pulse illegal, return to IDLE, no register read used, no writeback.
    - Otherwise go to EXEC.
  - EXEC (cycle 2):
    - alu_rsdata = rs_rdata and alu_rmdata = rm_rdata, registered at the READ->EXEC edge.
    - alu_n and the decoded bits are driven from the latched word.
    - Capture alu_result into the wb_data register at the end of the cycle; go to WB.
  - WB (cycle 3):
    - wb_en = 1 for exactly this cycle; wb_addr = latched instr[10:8].
    - Go to IDLE; instr_ready returns to 1 in cycle 4.
- Latency and throughput:
  - Accept to wb_en is 3 cycles.
  - Maximum rate is one instruction per 4 cycles.
- Stability: ALU inputs and decoded bits hold steady through EXEC. Outside EXEC they hold their last value and must not be used.
- Width rules: immediate is zero-extended ({8'b0, instr[7:0]}). No sign or carry handling in this block; the result is taken verbatim, truncated to DW.
- Hazards: none possible. A writeback completes before the next instruction's register read, because the register file writes on the WB edge.
- Reset mid-operation: any state returns to IDLE immediately; wb_en and illegal drop at once; a pending writeback is discarded.
- Simultaneous events: instr_valid during READ/EXEC/WB is ignored and not lost — it is held by the source until IDLE.

Test Plan:
- ADD R: R1=0x0005, R2=0x0003, instr=0x0140 -> wb_en in cycle 3, wb_addr=1, wb_data=0x0008. Check alu_bits12_11=00 during EXEC.
- SUB I: R3=0x0010, instr=0x1B05 -> alu_n=0x0005 in EXEC; wb_addr=3, wb_data=0x000B.
- ASR: R2=0x8004, instr=0x9210 -> wb_data=0xC002. LSR variant instr=0x9200 -> wb_data=0x4002.
- Illegal: instr=0x2000 (class 01) -> illegal pulse in cycle 1, no wb_en, instr_ready=1 in cycle 2. Repeat with instr=0x9800 (unsupported 111x) -> same response.
- Back-to-back: instr_valid held high with 0x0140 then 0x1B05 -> second accepted exactly 4 cycles after first; two wb_en pulses 4 cycles apart.
- Reset mid-op: reset_n low during EXEC of 0x0140 -> wb_en never asserts, busy=0 and instr_ready=1 immediately; next instruction after release executes normally.
